mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port (en/we/addr/wmask/wdata, rdata_valid/write_finish) between the instruction-fetch read requester and the MEM-stage data requester.
- Registers the winning request, holds it stable downstream until completion, and routes the completion pulse back to the owner.
- Suppresses responses for transactions killed by an exception flush.
- Data side has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_MAX, 4: consecutive lost arbitrations, with inst_en held, after which inst wins once. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- excp_flush  in  1  pipeline exception/ertn flush
- inst_en  in  1  fetch read request; held until inst_rdata_valid or flush
- inst_addr  in  32  fetch address
- inst_rdata  out  32  fetch read data
- inst_rdata_valid  out  1  one-cycle fetch completion
- data_en  in  1  data request; held until completion or flush
- data_we  in  1  1 = store, 0 = load
- data_addr  in  32  data address
- data_wmask  in  4  byte write mask
- data_wdata  in  32  store data
- data_rdata  out  32  load data
- data_rdata_valid  out  1  one-cycle load completion
- data_write_finish  out  1  one-cycle store completion
- mem_en  out  1  downstream request
- mem_we  out  1  downstream write enable
- mem_addr  out  32  downstream address
- mem_wmask  out  4  downstream mask (4'b0000 for inst reads)
- mem_wdata  out  32  downstream write data
- mem_rdata  in  32  downstream read data
- mem_rdata_valid  in  1  downstream read done
- mem_write_finish  in  1  downstream write done
- busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset values:
  - state = IDLE; all mem_* outputs 0; busy 0.
  - All *_valid and *_finish outputs 0.
  - drop = 0; starve_cnt = 0.
  - Reset mid-transaction abandons it; the downstream device is reset by the same reset.
- States: IDLE, INST, DATA.
- IDLE, excp_flush = 0:
  - Both requests: grant data, unless starve_cnt == STARVE_MAX, in which case grant inst.
  - Only one request: grant it. Neither: stay in IDLE.
  - On grant: latch addr/we/wmask/wdata into request regs (inst grant: we = 0, wmask = 0) and move to INST or DATA.
  - Latency: request visible in cycle N -> mem_en = 1 from cycle N+1.
- IDLE, excp_flush = 1: no grant that cycle.
- INST and DATA:
  - mem_en = 1; mem_* driven only from the latched regs and stable until completion.
  - Completion = mem_rdata_valid when the latched we = 0, mem_write_finish when we = 1. The other strobe is ignored.
  - Completion cycle M:
    - rdata is passed through combinationally.
    - The owner's valid/finish pulses in cycle M, gated by !drop && !excp_flush.
    - The next state is IDLE at M+1, with mem_en = 0 at M+1.
    - A new grant is possible at M+1, issued at M+2 (one bubble; no back-to-back).
- Flush:
  - excp_flush in INST or DATA sets drop.
  - The downstream transaction still runs to completion; it is never cancelled, including stores.
  - The response pulse is suppressed. drop clears on return to IDLE.
- Strobes outside a busy state: mem_rdata_valid or mem_write_finish in IDLE is ignored; no output pulse.
- starve_cnt:
  - +1 in each IDLE cycle where inst_en and data_en are both 1 and data is granted, saturating at STARVE_MAX.
  - Clears when inst is granted, or in any cycle with inst_en = 0.
- Non-owner outputs: valid/finish are always 0. data_rdata and inst_rdata both equal mem_rdata.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds outputs perf_inst_grant (32), perf_data_grant (32) and perf_wait (32):
  - Grant counters increment per grant.
  - perf_wait increments in each cycle where any requester's en = 1 and that requester is neither granted nor the current owner.
  - All three are 0 on reset and wrap modulo 2^32.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Data load only: data_en = 1, data_we = 0, data_addr = 0x1C000100 at cycle 0 -> mem_en = 1, mem_addr = 0x1C000100 at cycle 1; mem_rdata = 0xDEADBEEF with mem_rdata_valid at cycle 3 -> data_rdata_valid = 1 and data_rdata = 0xDEADBEEF at cycle 3; mem_en = 0 at cycle 4.
- Simultaneous requests: inst_en and data_en (store, wmask = 4'b0011) both 1 -> data granted first, mem_we = 1, mem_wmask = 4'b0011; after write_finish, inst issues two cycles later with mem_wmask = 0.
- Starvation, STARVE_MAX = 4: inst_en and data_en held high continuously -> data wins 4 consecutive grants, 5th grant goes to inst, then the data-priority pattern repeats.
- Flush mid-read: excp_flush pulse during INST before mem_rdata_valid -> mem_en stays 1 until mem_rdata_valid; inst_rdata_valid stays 0; next grant possible the following cycle.
- Flush mid-store: excp_flush during DATA with we = 1 -> write completes downstream, data_write_finish suppressed, busy = 0 the cycle after mem_write_finish.
- Reset mid-op: reset = 1 while in DATA -> next cycle state IDLE, mem_en = 0, busy = 0, starve_cnt = 0; a spurious mem_write_finish then produces no output pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and the MEM-stage data requester.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_rdata_valid,
  input  logic        data_en,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wmask,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_rdata_valid,
  output logic        data_write_finish,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  input  logic        mem_write_finish,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_inst_grant,
  output logic [31:0] perf_data_grant,
  output logic [31:0] perf_wait,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, INST = 2'd1, DATA = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_r;
  logic        req_we_r;
  logic [31:0] req_addr_r;
  logic [3:0]  req_wmask_r;
  logic [31:0] req_wdata_r;
  logic        drop_r;
  logic [3:0]  starve_cnt_r;

  logic grant_inst_s;
  logic grant_data_s;
  logic complete_s;
  logic resp_ok_s;

  // Grant decision: data has priority unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if (state_r == IDLE && !excp_flush) begin
      if (inst_en && data_en) begin
        if (starve_cnt_r == STARVE_LIM) begin
          grant_inst_s = 1'b1;
        end else begin
          grant_data_s = 1'b1;
        end
      end else if (inst_en) begin
        grant_inst_s = 1'b1;
      end else if (data_en) begin
        grant_data_s = 1'b1;
      end else begin
        grant_inst_s = 1'b0;
      end
    end else begin
      grant_inst_s = 1'b0;
    end
  end

  // Completion uses only the strobe matching the latched direction.
  always_comb begin
    complete_s = 1'b0;
    case (state_r)
      INST:    complete_s = mem_rdata_valid;
      DATA:    complete_s = req_we_r ? mem_write_finish : mem_rdata_valid;
      default: complete_s = 1'b0;
    endcase
  end

  assign resp_ok_s = complete_s && !drop_r && !excp_flush;

  assign inst_rdata        = mem_rdata;
  assign data_rdata        = mem_rdata;
  assign inst_rdata_valid  = resp_ok_s && (state_r == INST);
  assign data_rdata_valid  = resp_ok_s && (state_r == DATA) && !req_we_r;
  assign data_write_finish = resp_ok_s && (state_r == DATA) && req_we_r;

  assign busy      = (state_r != IDLE);
  assign mem_en    = (state_r != IDLE);
  assign mem_we    = req_we_r;
  assign mem_addr  = req_addr_r;
  assign mem_wmask = req_wmask_r;
  assign mem_wdata = req_wdata_r;

  // Transaction FSM with request latch; a flushed transaction still finishes downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_we_r    <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      req_wmask_r <= 4'b0000;
      req_wdata_r <= 32'h0000_0000;
      drop_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          drop_r <= 1'b0;
          if (grant_inst_s) begin
            state_r     <= INST;
            req_we_r    <= 1'b0;
            req_addr_r  <= inst_addr;
            req_wmask_r <= 4'b0000;
            req_wdata_r <= 32'h0000_0000;
          end else if (grant_data_s) begin
            state_r     <= DATA;
            req_we_r    <= data_we;
            req_addr_r  <= data_addr;
            req_wmask_r <= data_wmask;
            req_wdata_r <= data_wdata;
          end else begin
            state_r <= IDLE;
          end
        end
        INST, DATA: begin
          if (complete_s) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
          end else if (excp_flush) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
        end
        default: begin
          state_r <= IDLE;
          drop_r  <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: consecutive lost arbitrations while fetch keeps requesting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (!inst_en || grant_inst_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_data_s && starve_cnt_r != STARVE_LIM) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic inst_wait_s;
  logic data_wait_s;

  assign inst_wait_s = inst_en && !grant_inst_s && (state_r != INST);
  assign data_wait_s = data_en && !grant_data_s && (state_r != DATA);

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_grant <= 32'd0;
      perf_data_grant <= 32'd0;
      perf_wait       <= 32'd0;
    end else begin
      perf_inst_grant <= perf_inst_grant + {31'd0, grant_inst_s};
      perf_data_grant <= perf_data_grant + {31'd0, grant_data_s};
      perf_wait       <= perf_wait + {31'd0, (inst_wait_s || data_wait_s)};
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX = 4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_flush;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_rdata_valid;
  logic        data_en;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_wmask;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_rdata_valid;
  logic        data_write_finish;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_write_finish;
  logic        busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_grant;
  logic [31:0] perf_data_grant;
  logic [31:0] perf_wait;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h1C00_0100;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_rdata_valid(inst_rdata_valid),
    .data_en(data_en), .data_we(data_we), .data_addr(data_addr),
    .data_wmask(data_wmask), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_rdata_valid(data_rdata_valid), .data_write_finish(data_write_finish),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_write_finish(mem_write_finish),
`ifdef ARB_PERF_CNT_EN
    .perf_inst_grant(perf_inst_grant), .perf_data_grant(perf_data_grant),
    .perf_wait(perf_wait),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    excp_flush = 1'b0; inst_en = 1'b0; inst_addr = IADDR;
    data_en = 1'b0; data_we = 1'b0; data_addr = DADDR; data_wmask = 4'b0000;
    data_wdata = 32'h0; mem_rdata = 32'h0; mem_rdata_valid = 1'b0; mem_write_finish = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({mem_we, mem_addr, mem_wmask, mem_wdata} !== 69'd0) begin errors++;
      $display("FAIL reset_mem_bus got %h exp 0", {mem_we, mem_addr, mem_wmask, mem_wdata}); end
    checks++; if ({inst_rdata_valid, data_rdata_valid, data_write_finish} !== 3'b000) begin errors++;
      $display("FAIL reset_strobes got %b exp 000", {inst_rdata_valid, data_rdata_valid, data_write_finish}); end
    tick();
  endtask

  task automatic test_data_load();
    data_en = 1'b1; data_we = 1'b0; data_addr = 32'h1C00_0100;
    tick(); // cycle 1
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL load_mem_en got %b exp 1", mem_en); end
    checks++; if (mem_addr !== 32'h1C00_0100) begin errors++; $display("FAIL load_addr got %h exp 1c000100", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_we got %b exp 0", mem_we); end
    tick(); // cycle 2
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy); end
    tick(); // cycle 3
    mem_rdata = 32'hDEAD_BEEF; mem_rdata_valid = 1'b1;
    #1;
    checks++; if (data_rdata_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", data_rdata_valid); end
    checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", data_rdata); end
    checks++; if (inst_rdata_valid !== 1'b0) begin errors++; $display("FAIL load_inst_valid got %b exp 0", inst_rdata_valid); end
    tick(); // cycle 4
    data_en = 1'b0; mem_rdata_valid = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL load_done_mem_en got %b exp 0", mem_en); end
    tick();
  endtask

  task automatic test_simultaneous();
    inst_en = 1'b1; inst_addr = IADDR;
    data_en = 1'b1; data_we = 1'b1; data_addr = 32'h1C00_0200; data_wmask = 4'b0011; data_wdata = 32'h1234_5678;
    tick(); // cycle 1: data store owns the port
    mem_write_finish = 1'b1;
    #1;
    checks++; if ({mem_en, mem_we, mem_wmask} !== 6'b1_1_0011) begin errors++;
      $display("FAIL sim_store_ctrl got %b exp 110011", {mem_en, mem_we, mem_wmask}); end
    checks++; if (mem_addr !== 32'h1C00_0200 || mem_wdata !== 32'h1234_5678) begin errors++;
      $display("FAIL sim_store_bus got %h/%h exp 1c000200/12345678", mem_addr, mem_wdata); end
    checks++; if ({data_write_finish, inst_rdata_valid} !== 2'b10) begin errors++;
      $display("FAIL sim_store_finish got %b exp 10", {data_write_finish, inst_rdata_valid}); end
    tick(); // cycle 2: bubble, inst granted
    data_en = 1'b0; mem_write_finish = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL sim_bubble got %b exp 0", mem_en); end
    tick(); // cycle 3: inst issued
    mem_rdata = 32'hCAFE_0001; mem_rdata_valid = 1'b1;
    #1;
    checks++; if ({mem_en, mem_we, mem_wmask} !== 6'b1_0_0000 || mem_addr !== IADDR) begin errors++;
      $display("FAIL sim_inst_issue got %b %h exp 100000 %h", {mem_en, mem_we, mem_wmask}, mem_addr, IADDR); end
    checks++; if ({inst_rdata_valid, data_rdata_valid} !== 2'b10 || inst_rdata !== 32'hCAFE_0001) begin errors++;
      $display("FAIL sim_inst_valid got %b %h exp 10 cafe0001", {inst_rdata_valid, data_rdata_valid}, inst_rdata); end
    tick();
    inst_en = 1'b0; mem_rdata_valid = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_inst;
    inst_en = 1'b1; inst_addr = IADDR;
    data_en = 1'b1; data_we = 1'b0; data_addr = DADDR; data_wmask = 4'b0000;
    tick();
    for (int i = 0; i < 10; i++) begin
      exp_inst = (i == 4) || (i == 9);
      mem_rdata = 32'(i); mem_rdata_valid = 1'b1;
      #1;
      checks++; if (mem_en !== 1'b1 || mem_addr !== (exp_inst ? IADDR : DADDR)) begin errors++;
        $display("FAIL starve_grant%0d got en=%b addr=%h exp addr=%h", i, mem_en, mem_addr, exp_inst ? IADDR : DADDR); end
      checks++; if ({inst_rdata_valid, data_rdata_valid} !== {exp_inst, ~exp_inst}) begin errors++;
        $display("FAIL starve_owner%0d got %b exp %b", i, {inst_rdata_valid, data_rdata_valid}, {exp_inst, ~exp_inst}); end
      tick();
      mem_rdata_valid = 1'b0;
      tick();
    end
    inst_en = 1'b0; data_en = 1'b0;
    tick();
  endtask

  task automatic test_flush_read();
    inst_en = 1'b1; inst_addr = IADDR;
    tick(); // cycle 1: INST
    excp_flush = 1'b1; inst_en = 1'b0;
    tick(); // cycle 2
    excp_flush = 1'b0;
    #1;
    checks++; if ({mem_en, busy} !== 2'b11) begin errors++; $display("FAIL flushr_hold got %b exp 11", {mem_en, busy}); end
    tick(); // cycle 3: completion of the killed fetch
    mem_rdata_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    #1;
    checks++; if (inst_rdata_valid !== 1'b0) begin errors++; $display("FAIL flushr_suppress got %b exp 0", inst_rdata_valid); end
    tick(); // cycle 4: new fetch request
    mem_rdata_valid = 1'b0; inst_en = 1'b1; inst_addr = 32'h1C00_0040;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL flushr_idle got %b exp 0", mem_en); end
    tick(); // cycle 5
    mem_rdata_valid = 1'b1; mem_rdata = 32'h0000_0040;
    #1;
    checks++; if (mem_addr !== 32'h1C00_0040 || inst_rdata_valid !== 1'b1) begin errors++;
      $display("FAIL flushr_next got %h %b exp 1c000040 1", mem_addr, inst_rdata_valid); end
    tick();
    inst_en = 1'b0; mem_rdata_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_store();
    data_en = 1'b1; data_we = 1'b1; data_addr = DADDR; data_wmask = 4'b1111; data_wdata = 32'hA5A5_A5A5;
    tick(); // cycle 1: DATA
    excp_flush = 1'b1; data_en = 1'b0;
    #1;
    checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL flushs_issue got %b exp 11", {mem_en, mem_we}); end
    tick(); // cycle 2: downstream write completes
    excp_flush = 1'b0; mem_write_finish = 1'b1;
    #1;
    checks++; if (data_write_finish !== 1'b0 || mem_en !== 1'b1) begin errors++;
      $display("FAIL flushs_suppress got fin=%b en=%b exp 0 1", data_write_finish, mem_en); end
    tick(); // cycle 3
    mem_write_finish = 1'b0;
    #1;
    checks++; if ({busy, mem_en} !== 2'b00) begin errors++; $display("FAIL flushs_idle got %b exp 00", {busy, mem_en}); end
    tick();
  endtask

  task automatic test_flush_idle_and_strobe();
    data_en = 1'b1; data_we = 1'b0; excp_flush = 1'b1;
    tick();
    excp_flush = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL flushidle_nogrant got %b exp 0", mem_en); end
    tick(); // load granted last cycle; wrong-direction strobe is ignored
    mem_write_finish = 1'b1;
    #1;
    checks++; if ({mem_en, data_rdata_valid, data_write_finish} !== 3'b100) begin errors++;
      $display("FAIL wrong_strobe got %b exp 100", {mem_en, data_rdata_valid, data_write_finish}); end
    tick();
    mem_write_finish = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrong_strobe_busy got %b exp 1", busy); end
    mem_rdata_valid = 1'b1;
    tick();
    data_en = 1'b0; mem_rdata_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    inst_en = 1'b1; data_en = 1'b1; data_we = 1'b1; data_wmask = 4'b0001;
    tick(); // cycle 1: DATA, starvation count is non-zero
    reset = 1'b1;
    tick(); // cycle 2
    reset = 1'b0; inst_en = 1'b0; data_en = 1'b0;
    mem_write_finish = 1'b1;
    #1;
    checks++; if ({mem_en, busy, mem_we} !== 3'b000) begin errors++; $display("FAIL rstmid_state got %b exp 000", {mem_en, busy, mem_we}); end
    checks++; if (dut.starve_cnt_r !== 4'd0) begin errors++; $display("FAIL rstmid_starve got %0d exp 0", dut.starve_cnt_r); end
    checks++; if ({data_write_finish, data_rdata_valid, inst_rdata_valid} !== 3'b000) begin errors++;
      $display("FAIL rstmid_spurious got %b exp 000", {data_write_finish, data_rdata_valid, inst_rdata_valid}); end
    tick();
    mem_write_finish = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", mem_en); end
    tick();
  endtask

  initial begin
    test_reset();
    test_data_load();
    test_simultaneous();
    test_starvation();
    test_flush_read();
    test_flush_store();
    test_flush_idle_and_strobe();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
